// File: rtl/rbr_pkg.sv
// Shared definitions for the redundant-binary (signed-digit) datapath:
// digit encoding, digit decode helper and the on-the-fly converter states.
package rbr_pkg;

  // Two-bit signed-digit encoding produced by the online divider.
  // 2'b11 is not a legal digit and decodes as zero.
  typedef logic [1:0] signed_digit;

  localparam signed_digit SD_ZERO = 2'b00;
  localparam signed_digit SD_POS  = 2'b01;
  localparam signed_digit SD_NEG  = 2'b10;

  typedef enum logic [1:0] {
    OTF_IDLE,
    OTF_CONV,
    OTF_DONE
  } otf_state_t;

  // Decode one signed digit to -1/0/+1; anything that is not a legal
  // +1 or -1 encoding is treated as 0.
  function automatic logic signed [1:0] sd_value(signed_digit d);
    logic signed [1:0] v;
    case (d)
      SD_POS:  v = 2'sb01;
      SD_NEG:  v = 2'sb11;
      default: v = 2'sb00;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/online_otf_converter_otf_step.sv
// One on-the-fly conversion step: folds a single signed digit into the
// Q/QM register pair. Purely combinational so it can be chained to retire
// several digits per cycle later on.
module otf_step
  import rbr_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] q_cur,
  input  logic [W-1:0] qm_cur,
  input  signed_digit  d,
  output logic [W-1:0] q_next,
  output logic [W-1:0] qm_next
);

  logic [W-1:0]      q_dbl;
  logic [W-1:0]      qm_dbl;
  logic signed [1:0] d_val;

  // Doubling is a plain left shift; bits shifted out wrap modulo 2^W.
  assign q_dbl  = {q_cur[W-2:0], 1'b0};
  assign qm_dbl = {qm_cur[W-2:0], 1'b0};
  assign d_val  = sd_value(d);

  // Select the next Q/QM pair from the decoded digit; QM always tracks Q-1.
  always_comb begin
    q_next  = q_dbl;
    qm_next = {qm_dbl[W-1:1], 1'b1};
    case (d_val)
      2'sb01: begin
        q_next  = {q_dbl[W-1:1], 1'b1};
        qm_next = q_dbl;
      end
      2'sb11: begin
        q_next  = {qm_dbl[W-1:1], 1'b1};
        qm_next = qm_dbl;
      end
      default: begin
        q_next  = q_dbl;
        qm_next = {qm_dbl[W-1:1], 1'b1};
      end
    endcase
  end

endmodule

// File: rtl/online_otf_converter.sv
// MSD-first on-the-fly converter: turns one WIDTH-digit signed-digit
// quotient word into a (WIDTH+1)-bit two's-complement integer, one digit
// per cycle, with valid/ready handshakes on both sides.
module online_otf_converter
  import rbr_pkg::*;
#(
  parameter  int WIDTH = 15,
  localparam int OUT_W = WIDTH + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  signed_digit [WIDTH-1:0]  q_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         result
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  otf_state_t              state_q,  state_d;
  logic [OUT_W-1:0]        q_q,      q_d;
  logic [OUT_W-1:0]        qm_q,     qm_d;
  logic [CNT_W-1:0]        cnt_q,    cnt_d;
  signed_digit [WIDTH-1:0] sr_q,     sr_d;
  logic [OUT_W-1:0]        result_q, result_d;

  logic [OUT_W-1:0]        q_step;
  logic [OUT_W-1:0]        qm_step;
  logic                    accept;

  otf_step #(
    .W (OUT_W)
  ) u_step (
    .q_cur   (q_q),
    .qm_cur  (qm_q),
    .d       (sr_q[WIDTH-1]),
    .q_next  (q_step),
    .qm_next (qm_step)
  );

  // in_ready is gated by reset so it reads 0 while reset is held.
  assign in_ready  = rst_n && (state_q == OTF_IDLE);
  assign out_valid = (state_q == OTF_DONE);
  assign result    = result_q;
  assign accept    = in_valid && in_ready;

  // Next-state logic: load a word, retire one digit per cycle, then hold
  // the finished result until the consumer takes it.
  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    qm_d     = qm_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    result_d = result_q;
    case (state_q)
      OTF_IDLE: begin
        if (accept) begin
          sr_d    = q_in;
          q_d     = '0;
          qm_d    = '1;
          cnt_d   = '0;
          state_d = OTF_CONV;
        end
      end
      OTF_CONV: begin
        q_d   = q_step;
        qm_d  = qm_step;
        sr_d  = {sr_q[WIDTH-2:0], SD_ZERO};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          result_d = q_step;
          cnt_d    = '0;
          state_d  = OTF_DONE;
        end
      end
      OTF_DONE: begin
        if (out_ready) begin
          state_d = OTF_IDLE;
        end
      end
      default: begin
        state_d = OTF_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= OTF_IDLE;
      q_q      <= '0;
      qm_q     <= '1;
      cnt_q    <= '0;
      sr_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      qm_q     <= qm_d;
      cnt_q    <= cnt_d;
      sr_q     <= sr_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_online_otf_converter.sv
// Scoreboard bench for online_otf_converter: accepted words push their
// integer value (sum of d_i * 2^i) into a queue, and an independent monitor
// pops and compares whenever the converter hands over a result.
module tb_online_otf_converter;

  localparam int WIDTH  = 15;
  localparam int OUT_W  = WIDTH + 1;
  localparam int N_RAND = 2000;

  logic               clk       = 1'b0;
  logic               rst_n     = 1'b0;
  logic               in_valid  = 1'b0;
  logic               out_ready = 1'b1;
  logic [2*WIDTH-1:0] q_in      = '0;
  logic               in_ready;
  logic               out_valid;
  logic [OUT_W-1:0]   result;

  int n_compared   = 0;
  int n_mismatched = 0;
  int exp_q[$];
  bit rnd_active   = 1'b0;

  online_otf_converter #(
    .WIDTH (WIDTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .q_in      (q_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  // Digit encodings as seen on the wire: 01 = +1, 10 = -1, 00/11 = 0.
  function automatic logic [1:0] enc(int v);
    if (v > 0) return 2'b01;
    if (v < 0) return 2'b10;
    return 2'b00;
  endfunction

  // Reference value of a word: plain integer sum of digit * 2^i.
  function automatic int model(logic [2*WIDTH-1:0] w);
    int acc;
    logic [1:0] d;
    acc = 0;
    for (int i = 0; i < WIDTH; i++) begin
      d = w[2*i +: 2];
      if (d == 2'b01)      acc = acc + (1 << i);
      else if (d == 2'b10) acc = acc - (1 << i);
    end
    return acc;
  endfunction

  function automatic logic [2*WIDTH-1:0] fill(int v);
    logic [2*WIDTH-1:0] w;
    for (int i = 0; i < WIDTH; i++) w[2*i +: 2] = enc(v);
    return w;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_compared++;
    n_mismatched++;
    $display("[TB] FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  // Present a word and hold it until the converter accepts it; the expected
  // value is queued at the handshake. Returns at the negedge after the accept
  // edge with in_valid already dropped.
  task automatic applyStimulus(input logic [2*WIDTH-1:0] w);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      in_valid = 1'b1;
      q_in     = w;
      #3;
      if (in_ready) begin
        exp_q.push_back(model(w));
        ok = 1'b1;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (!ok) fail_now("accept_timeout");
  endtask

  task automatic drain(input int bound);
    for (int t = 0; t < bound && exp_q.size() > 0; t++) @(negedge clk);
    if (exp_q.size() > 0) begin
      fail_now("drain_timeout");
      exp_q.delete();
    end
  endtask

  function automatic logic [2*WIDTH-1:0] rand_word();
    logic [2*WIDTH-1:0] w;
    for (int i = 0; i < WIDTH; i++) w[2*i +: 2] = 2'($urandom_range(0, 3));
    return w;
  endfunction

  // Monitor: every completed output handshake is checked against the queue.
  always @(negedge clk) begin
    #3;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL unexpected_output: got %0d, expected no output", $signed(result));
      end else begin
        checkOutput("result", int'($signed(result)), exp_q.pop_front());
      end
    end
  end

  // Random consumer backpressure during the random phase.
  always @(negedge clk) begin
    if (rnd_active) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2*WIDTH-1:0] w;
    int bp_exp;
    bit seen;

    // Reset values while reset is held and right after release.
    #1;
    checkOutput("rst_in_ready", int'(in_ready), 0);
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_result", int'(result), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("post_rst_in_ready", int'(in_ready), 1);

    // All-zero word with latency check: out_valid only after the 15th edge.
    applyStimulus(fill(0));
    for (int k = 0; k <= WIDTH; k++) begin
      if (k > 0) @(negedge clk);
      #3;
      checkOutput($sformatf("latency_k%0d", k), int'(out_valid), (k == WIDTH) ? 1 : 0);
    end
    drain(50);

    // Boundary words.
    w = fill(0); w[2*(WIDTH-1) +: 2] = enc(1);
    applyStimulus(w); drain(50);
    w = fill(-1); w[2*(WIDTH-1) +: 2] = enc(1);
    applyStimulus(w); drain(50);
    w = fill(1); w[2*(WIDTH-1) +: 2] = enc(-1);
    applyStimulus(w); drain(50);
    applyStimulus(fill(1)); drain(50);
    applyStimulus(fill(-1)); drain(50);
    applyStimulus('1); drain(50);

    // Backpressure: result and in_ready hold while in_valid is pulsed.
    out_ready = 1'b0;
    w = rand_word();
    applyStimulus(w);
    bp_exp = model(w);
    seen = 1'b0;
    for (int t = 0; t < 40 && !seen; t++) begin
      #3;
      if (out_valid) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) fail_now("bp_out_valid_timeout");
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = c[0];
      q_in     = rand_word();
      #3;
      checkOutput("bp_out_valid", int'(out_valid), 1);
      checkOutput("bp_result", int'($signed(result)), bp_exp);
      checkOutput("bp_in_ready", int'(in_ready), 0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    applyStimulus(rand_word());
    #3;
    checkOutput("bp_single_accept", int'(in_ready), 0);
    drain(50);

    // Reset in the middle of a conversion drops the word.
    applyStimulus(rand_word());
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_in_ready", int'(in_ready), 0);
    checkOutput("midrst_out_valid", int'(out_valid), 0);
    checkOutput("midrst_result", int'(result), 0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("midrst_release_in_ready", int'(in_ready), 1);
    w = fill(0); w[2*(WIDTH-1) +: 2] = enc(1);
    applyStimulus(w);
    drain(50);

    // Random words (illegal 11 digits included) with random gaps and stalls.
    rnd_active = 1'b1;
    for (int n = 0; n < N_RAND; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      applyStimulus(rand_word());
    end
    drain(500);
    rnd_active = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
